// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request/result bus bundle for the shared-ALU scheduler
// Requester lanes are packed side by side: lane k owns a_i[32k+31:32k], op_i[3k+2:3k].
interface alu_sched_if #(
   parameter int N   = 4,
   parameter int IDW = 2
);
   logic [N-1:0]     req;
   logic [32*N-1:0]  a_i;
   logic [32*N-1:0]  b_i;
   logic [3*N-1:0]   op_i;
   logic [N-1:0]     gnt;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [IDW-1:0]   res_id;
   logic             res_err;

   modport master (
      output req, a_i, b_i, op_i, res_ready,
      input  gnt, busy, res_valid, res_data, res_id, res_err
   );

   modport slave (
      input  req, a_i, b_i, op_i, res_ready,
      output gnt, busy, res_valid, res_data, res_id, res_err
   );
endinterface

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler owning the single shared ALU
// One request in flight at a time; the result is held until the consumer takes it.
module alu_sched #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic       clk,
   input  logic       rst,
   alu_sched_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_POW = 3'd4;
   localparam logic [2:0] OP_MOD = 3'd5;
   localparam logic [2:0] OP_LS  = 3'd6;

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      res_data_q, res_data_d;
   logic             res_err_q, res_err_d;

   logic             found;
   logic [IDW-1:0]   win;
   logic [IDW:0]     cand;
   logic [31:0]      sel_a, sel_b;
   logic [2:0]       sel_op;
   logic [31:0]      alu_res;
   logic             alu_err;
   logic             div_ovf;
   logic [N-1:0]     gnt_w;
   logic             busy_w;
   logic             valid_w;

   // Counter preload is latency minus one so that cnt == 0 marks the final EXEC cycle.
   function automatic logic [2:0] exec_cycles_m1(input logic [2:0] op);
      logic [2:0] r;
      case (op)
         OP_MUL:                 r = 3'd2;
         OP_DIV, OP_MOD, OP_POW: r = 3'd7;
         default:                r = 3'd0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pow32(input logic [31:0] base, input logic [31:0] ex);
      logic [31:0] r;
      logic [31:0] p;
      r = 32'd1;
      p = base;
      for (int i = 0; i < 32; i++) begin
         if (ex[i]) r = r * p;
         p = p * p;
      end
      return r;
   endfunction

   // Round-robin search: first requester at or after last_granted + 1, wrapping at N.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = {1'b0, last_q} + (IDW+1)'(i);
         if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
         if (!found && bus.req[cand[IDW-1:0]]) begin
            found = 1'b1;
            win   = cand[IDW-1:0];
         end
      end
   end

   assign sel_a  = bus.a_i[32 * 32'(win) +: 32];
   assign sel_b  = bus.b_i[32 * 32'(win) +: 32];
   assign sel_op = bus.op_i[3 * 32'(win) +: 3];

   // The most-negative / -1 case is pinned explicitly so it wraps instead of trapping.
   assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op_q)
         OP_ADD: alu_res = a_q + b_q;
         OP_SUB: alu_res = a_q - b_q;
         OP_MUL: alu_res = a_q * b_q;
         OP_DIV: begin
            if (b_q == '0)   alu_err = 1'b1;
            else if (div_ovf) alu_res = a_q;
            else              alu_res = $signed(a_q) / $signed(b_q);
         end
         OP_POW: alu_res = pow32(a_q, b_q);
         OP_MOD: begin
            if (b_q == '0)   alu_err = 1'b1;
            else if (div_ovf) alu_res = '0;
            else              alu_res = $signed(a_q) % $signed(b_q);
         end
         OP_LS:  alu_res = {a_q[29:0], 2'b00};
         default: alu_res = {2'b00, a_q[31:2]};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (found) state_d = S_EXEC;
         S_EXEC:  if (cnt_q == 3'd0) state_d = S_DONE;
         S_DONE:  if (bus.res_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gnt_w   = '0;
      busy_w  = (state_q != S_IDLE);
      valid_w = (state_q == S_DONE);
      if (state_q == S_IDLE && found) gnt_w[win] = 1'b1;
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      id_d       = id_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               a_d    = sel_a;
               b_d    = sel_b;
               op_d   = sel_op;
               id_d   = win;
               last_d = win;
               cnt_d  = exec_cycles_m1(sel_op);
            end
         end
         S_EXEC: begin
            if (cnt_q == 3'd0) begin
               res_data_d = alu_res;
               res_err_d  = alu_err;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         id_q       <= '0;
         last_q     <= IDW'(N - 1);
         cnt_q      <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         id_q       <= id_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
      end
   end

   assign bus.gnt       = gnt_w;
   assign bus.busy      = busy_w;
   assign bus.res_valid = valid_w;
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = id_q;
   assign bus.res_err   = res_err_q;
endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - randomized and directed bench for alu_sched against a transaction model
module tb_alu_sched;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_sched_if #(.N(N), .IDW(IDW)) bus();
   alu_sched #(.N(N), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   // model state: one operation in flight, valid after its latency, cleared on handshake
   bit          m_busy;
   bit          m_valid;
   int          m_left;
   int          m_last;
   int          m_id;
   logic [31:0] m_data;
   logic        m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      int k;
      for (int i = 1; i <= N; i++) begin
         k = (last + i) % N;
         if (r[k] === 1'b1) return k;
      end
      return -1;
   endfunction

   function automatic int lat(input logic [2:0] op);
      case (op)
         3'd2:             return 3;
         3'd3, 3'd4, 3'd5: return 8;
         default:          return 1;
      endcase
   endfunction

   function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                   output logic [31:0] r, output logic e);
      longint sa, sb, t;
      logic [31:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0;
      e = 1'b0;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: begin t = sa * sb; r = t[31:0]; end
         3'd3: if (b == 0) e = 1'b1; else begin t = sa / sb; r = t[31:0]; end
         3'd4: begin p = 32'd1; for (int unsigned i = 0; i < b; i++) p = p * a; r = p; end
         3'd5: if (b == 0) e = 1'b1; else begin t = sa % sb; r = t[31:0]; end
         3'd6: r = a * 32'd4;
         default: r = a / 32'd4;
      endcase
   endfunction

   initial begin
      int w;
      logic [N-1:0] eg;
      logic [2:0] op;
      m_busy = 0; m_valid = 0; m_last = N - 1; m_id = 0; m_left = 0; m_data = '0; m_err = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_busy = 0; m_valid = 0; m_last = N - 1;
         end else if (!m_busy) begin
            w = rr_pick(bus.req, m_last);
            if (w >= 0) begin
               op = bus.op_i[3*w +: 3];
               ref_alu(bus.a_i[32*w +: 32], bus.b_i[32*w +: 32], op, m_data, m_err);
               m_busy = 1; m_last = w; m_id = w; m_left = lat(op);
            end
         end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1;
         end else if (bus.res_ready) begin
            m_busy = 0; m_valid = 0;
         end
         #1;
         if (rst) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_valid", bus.res_valid, 0);
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_data", bus.res_data, 0);
            chk("rst_id", bus.res_id, 0);
            chk("rst_err", bus.res_err, 0);
         end else begin
            eg = '0;
            if (!m_busy) begin
               w = rr_pick(bus.req, m_last);
               if (w >= 0) eg[w] = 1'b1;
            end
            chk("busy", bus.busy, m_busy);
            chk("valid", bus.res_valid, m_valid);
            chk("gnt", bus.gnt, eg);
            if (m_valid) begin
               chk("data", bus.res_data, m_data);
               chk("id", bus.res_id, m_id);
               chk("err", bus.res_err, m_err);
            end
         end
      end
   end

   task automatic set_lane(input int k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      bus.a_i[32*k +: 32] = a;
      bus.b_i[32*k +: 32] = b;
      bus.op_i[3*k +: 3]  = op;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      bus.req = '0;
      bus.res_ready = 1'b1;
      while ((bus.busy || bus.res_valid) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("drain", bus.busy, 0);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!bus.res_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk({name, "_valid"}, bus.res_valid, 1);
   endtask

   task automatic run_one(input string name, input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] ed, input logic ee, input int elat);
      int n;
      wait_idle();
      @(negedge clk);
      bus.res_ready = 1'b0;
      set_lane(k, a, b, op);
      bus.req = '0;
      bus.req[k] = 1'b1;
      #1;
      chk({name, "_gnt"}, bus.gnt, 32'(1) << k);
      @(posedge clk); #2;
      bus.req[k] = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.res_valid && n < 40);
      chk({name, "_lat"}, n, elat);
      chk({name, "_data"}, bus.res_data, ed);
      chk({name, "_err"}, bus.res_err, ee);
      chk({name, "_id"}, bus.res_id, k);
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      chk({name, "_hs"}, bus.res_valid, 0);
   endtask

   task automatic rand_lane(input int k);
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
         0: a = 32'h8000_0000;
         1: a = 32'hFFFF_FFFF;
         2: a = 32'($urandom_range(0, 20));
         default: ;
      endcase
      if (op == 3'd3 || op == 3'd5) begin
         if ($urandom_range(0, 3) == 0) b = '0;
         else if ($urandom_range(0, 1) == 0) begin
            b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 1) b = -b;
         end
      end
      if (op == 3'd4) b = 32'($urandom_range(0, 40));
      set_lane(k, a, b, op);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      logic e;
      int got, n;
      logic [N-1:0] g;

      rst = 1'b1;
      bus.req = '0; bus.a_i = '0; bus.b_i = '0; bus.op_i = '0; bus.res_ready = 1'b0;

      ref_alu(32'hFFFF_FFFD, 32'd4, 3'd2, r, e); chk("model_mul", r, 32'hFFFF_FFF4);
      ref_alu(32'd3, 32'd5, 3'd4, r, e);         chk("model_pow", r, 32'd243);
      ref_alu(32'd7, 32'd0, 3'd4, r, e);         chk("model_pow0", r, 32'd1);
      ref_alu(32'h8000_0000, 32'd0, 3'd7, r, e); chk("model_rs", r, 32'h2000_0000);
      ref_alu(32'hFFFF_FFF9, 32'd2, 3'd5, r, e); chk("model_mod", r, 32'hFFFF_FFFF);
      ref_alu(32'hFFFF_FFF9, 32'd2, 3'd3, r, e); chk("model_div_neg", r, 32'hFFFF_FFFD);
      ref_alu(32'd9, 32'd0, 3'd3, r, e);         chk("model_div0_err", e, 1);

      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_valid", bus.res_valid, 0);
      chk("reset_data", bus.res_data, 0);
      rst = 1'b0;

      run_one("add",  0, 32'd5,          32'd7, 3'd0, 32'd12,          1'b0, 1);
      run_one("mul",  1, 32'hFFFF_FFFD,  32'd4, 3'd2, 32'hFFFF_FFF4,   1'b0, 3);
      run_one("pow",  2, 32'd3,          32'd5, 3'd4, 32'd243,         1'b0, 8);
      run_one("rs",   3, 32'h8000_0000,  32'd0, 3'd7, 32'h2000_0000,   1'b0, 1);
      run_one("mod",  0, 32'hFFFF_FFF9,  32'd2, 3'd5, 32'hFFFF_FFFF,   1'b0, 8);
      run_one("div0", 1, 32'd9,          32'd0, 3'd3, 32'd0,           1'b1, 8);
      run_one("div",  1, 32'd9,          32'd2, 3'd3, 32'd4,           1'b0, 8);
      run_one("sub",  2, 32'd3,          32'd5, 3'd1, 32'hFFFF_FFFE,   1'b0, 1);
      run_one("ls",   3, 32'hC000_0001,  32'd0, 3'd6, 32'h0000_0004,   1'b0, 1);

      // round robin from a fresh reset: results name the requester order
      wait_idle();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < N; k++) set_lane(k, 32'(k), 32'd0, 3'd0);
      bus.req = '1;
      bus.res_ready = 1'b1;
      got = 0; n = 0;
      while (got < 5 && n < 100) begin
         @(posedge clk); #1; n++;
         if (bus.res_valid) begin
            chk("rr_data", bus.res_data, 32'(got % N));
            chk("rr_id", bus.res_id, 32'(got % N));
            got++;
         end
      end
      chk("rr_count", got, 5);

      // backpressure: held result, pending request must wait for the handshake
      wait_idle();
      @(negedge clk);
      bus.res_ready = 1'b0;
      set_lane(0, 32'd1, 32'd2, 3'd0);
      bus.req[0] = 1'b1;
      @(posedge clk); #2;
      bus.req[0] = 1'b0;
      wait_valid("bp");
      @(negedge clk);
      set_lane(1, 32'd10, 32'd20, 3'd0);
      bus.req[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", bus.res_valid, 1);
         chk("bp_hold_data", bus.res_data, 32'd3);
         chk("bp_hold_gnt", bus.gnt, 0);
      end
      @(negedge clk);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", bus.res_valid, 0);
      chk("bp_next_gnt", bus.gnt, 32'b0010);
      @(posedge clk); #2;
      bus.req[1] = 1'b0;
      chk("bp_next_busy", bus.busy, 1);

      // reset during the 4th EXEC cycle of a DIV granted to requester 2
      wait_idle();
      @(negedge clk);
      bus.res_ready = 1'b0;
      set_lane(2, 32'd100, 32'd3, 3'd3);
      bus.req[2] = 1'b1;
      @(posedge clk); #2;
      bus.req[2] = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_valid", bus.res_valid, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < N; k++) set_lane(k, 32'(100 + k), 32'd0, 3'd0);
      bus.req = '1;
      #1;
      chk("post_rst_gnt", bus.gnt, 32'b0001);
      @(posedge clk); #2;
      bus.req = '0;
      wait_valid("post_rst");
      chk("post_rst_id", bus.res_id, 0);
      chk("post_rst_data", bus.res_data, 32'd100);

      // randomized traffic: requests held until granted, random consumer backpressure
      wait_idle();
      g = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) if (g[k]) bus.req[k] = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!bus.req[k] && $urandom_range(0, 3) == 0) begin
               rand_lane(k);
               bus.req[k] = 1'b1;
            end
         end
         bus.res_ready = ($urandom_range(0, 1) == 1);
         #4;
         g = bus.gnt;
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_sched.md
# alu_sched

Shared-ALU scheduler: arbitrates up to N requesters onto one 32-bit, 8-operation ALU datapath (ADD, SUB, MUL, DIV, POW, MOD, shift-left-2, shift-right-2). It captures one request at a time, models a fixed per-opcode execution latency, and returns the result with the requester's ID over a valid/ready interface. It sits between the compute clients and the ALU function and owns every ALU access in the design.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `IDW`, default 2: ID width, equal to clog2(N).
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, N: per-requester request. Held until the matching `gnt`.
- `a_i`, input, 32*N: operand a. Requester k uses bits [32k+31:32k].
- `b_i`, input, 32*N: operand b, same packing.
- `op_i`, input, 3*N: opcode, [3k+2:3k]. Encoding: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 POW, 101 MOD, 110 L_S, 111 R_S.
- `gnt`, output, N: one-hot acceptance. Combinational, high only in IDLE.
- `busy`, output, 1: high when state is not IDLE.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_data`, output, 32: result.
- `res_id`, output, IDW: index of the requester that owns the result.
- `res_err`, output, 1: divide or modulo by zero.

## Operation
- FSM states:
  - IDLE: if any `req` is high, `gnt` goes to the winner and the winner's a, b, op and ID are captured at the clock edge. Next state is EXEC, with cnt = E(op) − 1.
  - EXEC: cnt decrements each cycle. At the edge where cnt == 0, the result and error are registered and the FSM moves to DONE.
  - DONE: `res_valid` = 1. When `res_valid && res_ready`, the FSM returns to IDLE at that edge.
- Arbitration is round-robin:
  - Search starts at (last_granted + 1) mod N.
  - Reset sets last_granted = N−1, so requester 0 has first priority.
  - last_granted updates only on a grant.
- `gnt` is 0 in EXEC and DONE. A `req` arriving then waits.
- Latency E(op):
  - ADD, SUB, L_S, R_S: 1
  - MUL: 3
  - DIV, MOD, POW: 8
- Arithmetic: a and b are 32-bit two's-complement signed. Results are truncated to 32 bits.
  - ADD, SUB and MUL wrap.
  - DIV truncates toward zero. MOD takes the sign of a.
  - L_S = a<<2. R_S = logical a>>2, zero-filled.
  - POW = a^b mod 2^32, with b treated as unsigned. b = 0 gives 1.
- Divide by zero (DIV or MOD with b == 0): `res_data` = 0 and `res_err` = 1. `res_err` is 0 for every other case.
- The computed result may come from a combinational function of the captured operands. Observable latency is always exactly E(op).

## Timing
- Reset values:
  - FSM state = IDLE, `gnt` = 0, `busy` = 0, `res_valid` = 0.
  - `res_data` = 0, `res_id` = 0, `res_err` = 0, last_granted = N−1.
- A request captured at edge T raises `res_valid` after edge T+E(op).
- `res_data`, `res_id` and `res_err` stay stable while `res_valid` is high and `res_ready` is low.
- After the handshake edge, the FSM spends at least one cycle in IDLE before the next capture. Back-to-back throughput is one op per E+2 cycles at best.
- If `res_ready` is already high when `res_valid` rises, the handshake completes in that same cycle.
- Reset asserted mid-EXEC or mid-DONE: the operation is discarded and no `res_valid` is issued. All outputs return to their reset values asynchronously.
- Requests and `res_ready` are sampled only at rising edges. Changes to `req` or operands outside IDLE have no effect.

## Test plan
- ADD, single request: requester 0 with a=5, b=7, op=000. Expect `gnt`=0001 for one cycle, then `res_valid` one cycle after capture with `res_data`=12, `res_id`=0, `res_err`=0.
- Round-robin with all requesters held high and `res_ready`=1: grants in order 0,1,2,3,0. Each op is ADD with a = its requester index and b=0, so the results identify the grant order.
- Latency and arithmetic, each checked for data and cycle count:
  - MUL a=−3, b=4 gives 0xFFFFFFF4 after 3 cycles.
  - POW a=3, b=5 gives 243 after 8 cycles.
  - R_S a=0x80000000 gives 0x20000000.
  - MOD a=−7, b=2 gives 0xFFFFFFFF.
- Divide by zero: DIV a=9, b=0 gives `res_data`=0, `res_err`=1. A following DIV a=9, b=2 gives 4 with `res_err`=0.
- Backpressure: hold `res_ready`=0 for 10 cycles after `res_valid`. Outputs must stay stable, `gnt` must stay 0 despite a pending `req`, and the next grant must come only after the handshake.
- Reset mid-operation: assert `rst` during the 4th EXEC cycle of a DIV. Expect no `res_valid`, `busy`=0 immediately, and after release requester 0 gets first priority.
